// File: rtl/sdram_resp_model.sv
// sdram_resp_model: behavioural SDRAM device responder (4 banks, 11-bit rows,
// 8-bit columns, 16-bit data) that answers the controller's command pins
// from an internal RAM.
// Build option: define SDRAM_RESP_CHECK_EN to compile in the protocol checker
// (err_valid/err_code); otherwise both outputs are tied low.
module sdram_resp_model #(
    parameter int unsigned DW       = 16,
    parameter int unsigned MEM_AW   = 10,
    parameter int unsigned ROW_BITS = 11,
    parameter int unsigned COL_BITS = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sdram_cke,
    input  logic          sdram_cs_n,
    input  logic          sdram_ras_n,
    input  logic          sdram_cas_n,
    input  logic          sdram_we_n,
    input  logic [1:0]    sdram_ba,
    input  logic [12:0]   sdram_addr,
    input  logic [DW-1:0] dq_in,
    output logic [DW-1:0] dq_out,
    output logic          dq_oe,
    output logic [3:0]    bank_open,
    output logic          err_valid,
    output logic [2:0]    err_code
);

    localparam int unsigned NBANK     = 4;
    localparam int unsigned MEM_DEPTH = 1 << MEM_AW;

    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_BST = 4'b0110;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_LMR = 4'b0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    // Flattened {bank,row,col} truncated to the RAM size; aliasing is intended.
    function automatic logic [MEM_AW-1:0] mem_idx(input logic [1:0]          ba,
                                                  input logic [ROW_BITS-1:0] row,
                                                  input logic [COL_BITS-1:0] col);
        return MEM_AW'({ba, row, col});
    endfunction

    logic [DW-1:0] mem [MEM_DEPTH];

    state_e                          state_q, state_d;
    logic [1:0]                      burst_ba_q, burst_ba_d;
    logic [ROW_BITS-1:0]             burst_row_q, burst_row_d;
    logic [COL_BITS-1:0]             col_q, col_d;
    logic [COL_BITS-1:0]             cnt_q, cnt_d;
    logic [NBANK-1:0]                open_q, open_d;
    logic [NBANK-1:0][ROW_BITS-1:0]  row_q, row_d;
    logic                            mode_set_q, mode_set_d;
    logic                            cl2_q, cl2_d;
    logic [COL_BITS-1:0]             bl_m1_q, bl_m1_d;
    logic                            p0_vld_q, p0_vld_d, p1_vld_q, p1_vld_d;
    logic [DW-1:0]                   p0_dat_q, p0_dat_d, p1_dat_q, p1_dat_d;
    logic [DW-1:0]                   dq_out_q, dq_out_d;
    logic                            dq_oe_q, dq_oe_d;

    logic [3:0]          cmd_c;
    logic [ROW_BITS-1:0] cmd_row_c;
    logic [COL_BITS-1:0] cmd_col_c;
    logic                xfer_c, xfer_rd_c;
    logic [MEM_AW-1:0]   xfer_idx_c;
    logic                unused_c;

    // Command decode; a closed bank addresses row 0.
    assign cmd_c     = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};
    assign cmd_row_c = open_q[sdram_ba] ? row_q[sdram_ba] : '0;
    assign cmd_col_c = sdram_addr[COL_BITS:1];
    assign unused_c  = ^sdram_addr[12:11];

    // Next-state: mode/bank bookkeeping, burst sequencing and read pipeline.
    always_comb begin
        state_d     = state_q;
        burst_ba_d  = burst_ba_q;
        burst_row_d = burst_row_q;
        col_d       = col_q;
        cnt_d       = cnt_q;
        open_d      = open_q;
        row_d       = row_q;
        mode_set_d  = mode_set_q;
        cl2_d       = cl2_q;
        bl_m1_d     = bl_m1_q;
        p0_vld_d    = p0_vld_q;
        p0_dat_d    = p0_dat_q;
        p1_vld_d    = p1_vld_q;
        p1_dat_d    = p1_dat_q;
        dq_out_d    = dq_out_q;
        dq_oe_d     = dq_oe_q;
        xfer_c      = 1'b0;
        xfer_rd_c   = 1'b0;
        xfer_idx_c  = '0;

        if (sdram_cke) begin
            case (cmd_c)
                CMD_LMR: begin
                    mode_set_d = 1'b1;
                    cl2_d      = (sdram_addr[6:4] == 3'b010);
                    case (sdram_addr[2:0])
                        3'b001:  bl_m1_d = COL_BITS'(1);
                        3'b010:  bl_m1_d = COL_BITS'(3);
                        3'b011:  bl_m1_d = COL_BITS'(7);
                        3'b111:  bl_m1_d = COL_BITS'(255);
                        default: bl_m1_d = COL_BITS'(0);
                    endcase
                end
                CMD_ACT: begin
                    open_d[sdram_ba] = 1'b1;
                    row_d[sdram_ba]  = sdram_addr[ROW_BITS-1:0];
                end
                CMD_PRE: begin
                    if (sdram_addr[10]) open_d = '0;
                    else                open_d[sdram_ba] = 1'b0;
                end
                default: ;
            endcase

            if (cmd_c == CMD_RD || cmd_c == CMD_WR) begin
                xfer_c      = 1'b1;
                xfer_rd_c   = (cmd_c == CMD_RD);
                xfer_idx_c  = mem_idx(sdram_ba, cmd_row_c, cmd_col_c);
                burst_ba_d  = sdram_ba;
                burst_row_d = cmd_row_c;
                col_d       = cmd_col_c + COL_BITS'(1);
                cnt_d       = bl_m1_q;
                if (bl_m1_q == '0)          state_d = ST_IDLE;
                else if (cmd_c == CMD_RD)   state_d = ST_READ;
                else                        state_d = ST_WRITE;
            end else if (state_q != ST_IDLE) begin
                if (cmd_c == CMD_BST ||
                    (cmd_c == CMD_PRE && (sdram_addr[10] || sdram_ba == burst_ba_q))) begin
                    state_d = ST_IDLE;
                end else begin
                    xfer_c     = 1'b1;
                    xfer_rd_c  = (state_q == ST_READ);
                    xfer_idx_c = mem_idx(burst_ba_q, burst_row_q, col_q);
                    col_d      = col_q + COL_BITS'(1);
                    cnt_d      = cnt_q - COL_BITS'(1);
                    if (cnt_q == COL_BITS'(1)) state_d = ST_IDLE;
                end
            end

            p0_vld_d = xfer_c && xfer_rd_c;
            p0_dat_d = p0_vld_d ? mem[xfer_idx_c] : '0;
            p1_vld_d = p0_vld_q;
            p1_dat_d = p0_dat_q;
            dq_oe_d  = cl2_q ? p0_vld_q : p1_vld_q;
            dq_out_d = cl2_q ? p0_dat_q : p1_dat_q;
        end
    end

    // State registers; RAM contents are deliberately left out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            burst_ba_q  <= '0;
            burst_row_q <= '0;
            col_q       <= '0;
            cnt_q       <= '0;
            open_q      <= '0;
            row_q       <= '0;
            mode_set_q  <= 1'b0;
            cl2_q       <= 1'b0;
            bl_m1_q     <= '0;
            p0_vld_q    <= 1'b0;
            p0_dat_q    <= '0;
            p1_vld_q    <= 1'b0;
            p1_dat_q    <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_ba_q  <= burst_ba_d;
            burst_row_q <= burst_row_d;
            col_q       <= col_d;
            cnt_q       <= cnt_d;
            open_q      <= open_d;
            row_q       <= row_d;
            mode_set_q  <= mode_set_d;
            cl2_q       <= cl2_d;
            bl_m1_q     <= bl_m1_d;
            p0_vld_q    <= p0_vld_d;
            p0_dat_q    <= p0_dat_d;
            p1_vld_q    <= p1_vld_d;
            p1_dat_q    <= p1_dat_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
        end
    end

    // Write-burst storage, one word per active write cycle.
    always_ff @(posedge clk) begin
        if (xfer_c && !xfer_rd_c) mem[xfer_idx_c] <= dq_in;
    end

    assign dq_out    = dq_out_q;
    assign dq_oe     = dq_oe_q;
    assign bank_open = open_q;

`ifdef SDRAM_RESP_CHECK_EN
    logic       err_valid_q, err_valid_d;
    logic [2:0] err_code_q, err_code_d;

    // Protocol checks on the sampled command; one code per offending edge.
    always_comb begin
        err_valid_d = 1'b0;
        err_code_d  = 3'd0;
        if (sdram_cke) begin
            case (cmd_c)
                CMD_RD, CMD_WR: begin
                    if (!mode_set_q) begin
                        err_valid_d = 1'b1;
                        err_code_d  = 3'd3;
                    end else if (!open_q[sdram_ba]) begin
                        err_valid_d = 1'b1;
                        err_code_d  = 3'd1;
                    end else if (sdram_addr[0]) begin
                        err_valid_d = 1'b1;
                        err_code_d  = 3'd4;
                    end
                end
                CMD_ACT: begin
                    if (open_q[sdram_ba]) begin
                        err_valid_d = 1'b1;
                        err_code_d  = 3'd2;
                    end
                end
                CMD_REF: begin
                    if (|open_q) begin
                        err_valid_d = 1'b1;
                        err_code_d  = 3'd5;
                    end
                end
                default: ;
            endcase
        end
    end

    // Violation pulse register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_valid_q <= 1'b0;
            err_code_q  <= 3'd0;
        end else begin
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
        end
    end

    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;
`else
    assign err_valid = 1'b0;
    assign err_code  = 3'd0;
`endif

endmodule

// File: tb/tb_sdram_resp_model.sv
// tb_sdram_resp_model: directed test of sdram_resp_model. Inputs change on the
// falling edge; outputs are sampled on the falling edge, so a value read after
// edge e is the one the controller samples at edge e+1.
module tb_sdram_resp_model;

    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] ACT = 4'b0011;
    localparam logic [3:0] RD  = 4'b0101;
    localparam logic [3:0] WR  = 4'b0100;
    localparam logic [3:0] BST = 4'b0110;
    localparam logic [3:0] PRE = 4'b0010;
    localparam logic [3:0] REF = 4'b0001;
    localparam logic [3:0] LMR = 4'b0000;

`ifdef SDRAM_RESP_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cke, cs_n, ras_n, cas_n, we_n;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic [15:0] dq_in;
    logic [15:0] dq_out;
    logic        dq_oe;
    logic [3:0]  bank_open;
    logic        err_valid;
    logic [2:0]  err_code;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sdram_resp_model dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sdram_cke  (cke),
        .sdram_cs_n (cs_n),
        .sdram_ras_n(ras_n),
        .sdram_cas_n(cas_n),
        .sdram_we_n (we_n),
        .sdram_ba   (ba),
        .sdram_addr (addr),
        .dq_in      (dq_in),
        .dq_out     (dq_out),
        .dq_oe      (dq_oe),
        .bank_open  (bank_open),
        .err_valid  (err_valid),
        .err_code   (err_code)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a,
                         input logic [15:0] d);
        {cs_n, ras_n, cas_n, we_n} = c;
        ba    = b;
        addr  = a;
        dq_in = d;
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic [3:0] c, input logic [1:0] b, input logic [12:0] a,
                         input logic [15:0] d);
        drive(c, b, a, d);
        tick();
    endtask

    function automatic logic [2:0] ec(input logic [2:0] c);
        return CHK ? c : 3'd0;
    endfunction

    // CL=3 read of nw words from bank 0, stopped with BURST STOP nw edges after READ.
    task automatic read_chk(input string tag, input logic [12:0] a, input int nw,
                            input logic [15:0] base);
        issue(RD, 2'd0, a, 16'h0);
        for (int e = 1; e <= nw + 2; e++) begin
            issue((e == nw) ? BST : NOP, 2'd0, 13'h0, 16'h0);
            if (e == 1) begin
                check_eq($sformatf("%s_oe_lat", tag), 32'(dq_oe), 32'd0);
            end else if (e <= nw + 1) begin
                check_eq($sformatf("%s_oe%0d", tag, e - 2), 32'(dq_oe), 32'd1);
                check_eq($sformatf("%s_w%0d", tag, e - 2), 32'(dq_out), 32'(base) + 32'(e - 2));
            end else begin
                check_eq($sformatf("%s_oe_end", tag), 32'(dq_oe), 32'd0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cke   = 1'b1;
        rst_n = 1'b0;
        drive(NOP, 2'd0, 13'h0, 16'h0);
        repeat (3) tick();
        check_eq("rst_dq_oe", 32'(dq_oe), 32'd0);
        check_eq("rst_dq_out", 32'(dq_out), 32'd0);
        check_eq("rst_bank_open", 32'(bank_open), 32'd0);
        check_eq("rst_err_valid", 32'(err_valid), 32'd0);
        check_eq("rst_err_code", 32'(err_code), 32'd0);
        rst_n = 1'b1;
        tick();

        // Activate, then a write before LOAD MODE (BL=1 from reset).
        issue(ACT, 2'd0, 13'h005, 16'h0);
        check_eq("act0_open", 32'(bank_open), 32'h1);
        check_eq("act0_noerr", 32'(err_valid), 32'd0);
        issue(WR, 2'd0, 13'h100, 16'h1234);
        check_eq("wr_nomode_v", 32'(err_valid), 32'(CHK));
        check_eq("wr_nomode_c", 32'(err_code), 32'(ec(3'd3)));
        issue(LMR, 2'd0, 13'h037, 16'h0);
        check_eq("lmr_err_clr", 32'(err_valid), 32'd0);
        check_eq("lmr_dq_oe", 32'(dq_oe), 32'd0);
        issue(ACT, 2'd0, 13'h005, 16'h0);
        check_eq("act_open_v", 32'(err_valid), 32'(CHK));
        check_eq("act_open_c", 32'(err_code), 32'(ec(3'd2)));

        // Sentinel at col 0x18, then an 8-word write at col 0x10 stopped at k=8.
        issue(WR, 2'd0, 13'h030, 16'h5555);
        issue(BST, 2'd0, 13'h0, 16'h6666);
        issue(WR, 2'd0, 13'h020, 16'hA000);
        for (int k = 1; k < 8; k++) issue(NOP, 2'd0, 13'h0, 16'hA000 + 16'(k));
        issue(BST, 2'd0, 13'h0, 16'hDEAD);
        issue(NOP, 2'd0, 13'h0, 16'h0);

        read_chk("rd10", 13'h020, 4, 16'hA000);
        read_chk("rd18", 13'h030, 1, 16'h5555);
        read_chk("rd80", 13'h100, 1, 16'h1234);

        // CL=2, BL=2 read ends by itself after two words.
        issue(LMR, 2'd0, 13'h021, 16'h0);
        issue(RD, 2'd0, 13'h02C, 16'h0);
        check_eq("cl2_oe_lat", 32'(dq_oe), 32'd0);
        issue(NOP, 2'd0, 13'h0, 16'h0);
        check_eq("cl2_oe0", 32'(dq_oe), 32'd1);
        check_eq("cl2_w0", 32'(dq_out), 32'hA006);
        issue(NOP, 2'd0, 13'h0, 16'h0);
        check_eq("cl2_w1", 32'(dq_out), 32'hA007);
        issue(NOP, 2'd0, 13'h0, 16'h0);
        check_eq("cl2_oe_end", 32'(dq_oe), 32'd0);

        // Full-page write wrapping from col 0xFE to 0x01 in the same row.
        issue(LMR, 2'd0, 13'h037, 16'h0);
        issue(WR, 2'd0, 13'h1FC, 16'hB000);
        for (int k = 1; k < 4; k++) issue(NOP, 2'd0, 13'h0, 16'hB000 + 16'(k));
        issue(BST, 2'd0, 13'h0, 16'hBEEF);
        issue(NOP, 2'd0, 13'h0, 16'h0);
        read_chk("rdwrap", 13'h1FC, 4, 16'hB000);
        read_chk("rdcol0", 13'h000, 1, 16'hB002);

        // Bank bookkeeping and checker codes 1 and 5.
        issue(PRE, 2'd0, 13'h400, 16'h0);
        check_eq("preall_open", 32'(bank_open), 32'h0);
        issue(RD, 2'd1, 13'h000, 16'h0);
        check_eq("rd_closed_v", 32'(err_valid), 32'(CHK));
        check_eq("rd_closed_c", 32'(err_code), 32'(ec(3'd1)));
        issue(BST, 2'd0, 13'h0, 16'h0);
        check_eq("err_pulse_end", 32'(err_valid), 32'd0);
        repeat (4) issue(NOP, 2'd0, 13'h0, 16'h0);
        issue(ACT, 2'd2, 13'h007, 16'h0);
        issue(ACT, 2'd3, 13'h009, 16'h0);
        check_eq("act23_open", 32'(bank_open), 32'hC);
        issue(PRE, 2'd2, 13'h000, 16'h0);
        check_eq("pre2_open", 32'(bank_open), 32'h8);
        issue(REF, 2'd0, 13'h0, 16'h0);
        check_eq("ref_open_v", 32'(err_valid), 32'(CHK));
        check_eq("ref_open_c", 32'(err_code), 32'(ec(3'd5)));
        issue(NOP, 2'd0, 13'h0, 16'h0);

        // Asynchronous reset in the middle of a read burst.
        issue(ACT, 2'd0, 13'h005, 16'h0);
        issue(RD, 2'd0, 13'h020, 16'h0);
        issue(NOP, 2'd0, 13'h0, 16'h0);
        issue(NOP, 2'd0, 13'h0, 16'h0);
        check_eq("mid_oe", 32'(dq_oe), 32'd1);
        check_eq("mid_w0", 32'(dq_out), 32'hA000);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_oe", 32'(dq_oe), 32'd0);
        check_eq("arst_out", 32'(dq_out), 32'd0);
        check_eq("arst_open", 32'(bank_open), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            issue(NOP, 2'd0, 13'h0, 16'h0);
            check_eq($sformatf("post_rst_oe%0d", i), 32'(dq_oe), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
